// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Operand signedness: rs1 is signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM.
  function automatic logic a_signed(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Small add/subtract ALU used for the per-iteration step of muldiv_seq.
module alu
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide: 32 shift-add / restoring-divide steps, then sign fix.
// Divide/remainder hardware is present only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

`ifdef MULDIV_SEQ_DIV_EN
  localparam int AW = XLEN + 2;  // divide trial needs a borrow bit above the 33-bit partial remainder
`else
  localparam int AW = XLEN + 1;
`endif

  state_e            state;
  logic [4:0]        cnt;
  logic              fix_stage;
  op_e               op_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] acc_fix;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;

  op_e               op_in;
  logic              sgn_a;
  logic              sgn_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   addend;

  logic [3:0]        alu_op;
  logic [AW-1:0]     alu_a;
  logic [AW-1:0]     alu_b;
  logic [AW-1:0]     alu_y;

`ifdef MULDIV_SEQ_DIV_EN
  logic              neg_r;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   a_q;
`endif

  assign op_in = op_e'(op);

  always_comb begin
    sgn_a = a_signed(op_in) & a[XLEN-1];
    sgn_b = b_signed(op_in) & b[XLEN-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; add into the top, shift right.
  // Divide:   acc = {partial remainder, dividend/quotient bits}; trial-subtract, shift left.
  always_comb begin
    addend   = acc[0] ? opnd : {XLEN{1'b0}};
    alu_op   = ALU_ADD;
    alu_a    = {{(AW-XLEN){1'b0}}, acc[2*XLEN-1:XLEN]};
    alu_b    = {{(AW-XLEN){1'b0}}, addend};
    acc_step = {alu_y[XLEN:0], acc[XLEN-1:1]};
    acc_fix  = neg_q ? -acc : acc;
`ifdef MULDIV_SEQ_DIV_EN
    if (is_div(op_q)) begin
      alu_op   = ALU_SUB;
      alu_a    = {1'b0, acc[2*XLEN-1:XLEN-1]};
      alu_b    = {2'b00, opnd};
      acc_step = alu_y[AW-1] ? {acc[2*XLEN-2:0], 1'b0}
                             : {alu_y[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      acc_fix  = {neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN],
                  neg_q ? -acc[XLEN-1:0]      : acc[XLEN-1:0]};
    end
`endif
  end

  alu #(.WIDTH(AW)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // NOTE: all state, including the datapath registers, uses non-blocking assignments
  // and is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fix_stage <= 1'b0;
      op_q      <= OP_MUL;
      acc       <= '0;
      opnd      <= '0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= op_in;
            cnt       <= '0;
            fix_stage <= 1'b0;
            neg_q     <= sgn_a ^ sgn_b;
            if (is_div(op_in)) begin
              acc  <= {{XLEN{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{XLEN{1'b0}}, mag_b};
              opnd <= mag_a;
            end
`ifdef MULDIV_SEQ_DIV_EN
            neg_r <= sgn_a;
            div0  <= (b == '0);
            ovf   <= a_signed(op_in) && (a == INT_MIN) && (b == '1);
            a_q   <= a;
            state <= S_BUSY;
            busy  <= 1'b1;
`else
            if (is_div(op_in)) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= S_BUSY;
              busy  <= 1'b1;
            end
`endif
          end
        end

        S_BUSY: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= S_FIX;
        end

        // First FIX cycle restores signs; second applies special cases and publishes.
        S_FIX: begin
          if (!fix_stage) begin
            fix_stage <= 1'b1;
            acc       <= acc_fix;
          end else begin
            fix_stage <= 1'b0;
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            case (op_q)
              OP_MUL:                       result <= acc[XLEN-1:0];
              OP_MULH, OP_MULHSU, OP_MULHU: result <= acc[2*XLEN-1:XLEN];
`ifdef MULDIV_SEQ_DIV_EN
              OP_DIV, OP_DIVU: result <= div0 ? DIV0_Q : (ovf ? INT_MIN : acc[XLEN-1:0]);
              OP_REM, OP_REMU: result <= div0 ? a_q : (ovf ? '0 : acc[2*XLEN-1:XLEN]);
`endif
              default:                      result <= '0;
            endcase
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: function, latency, busy/done framing, reset abort.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int LAT = 35;
`ifdef MULDIV_SEQ_DIV_EN
  localparam int LAT_DIV = 35;
`else
  localparam int LAT_DIV = 1;
`endif

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a request; returns at the negedge of the first cycle after the accepting edge.
  task automatic issue(input op_e o, input logic [31:0] x, input logic [31:0] y, input bit now);
    if (!now) @(negedge clk);
    op_i  = o;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k=1 is the first cycle after acceptance; optionally re-pulses start at cycle poke_at.
  task automatic wait_done(input int poke_at, input int tail, output int lat, output int bc,
                           output int ovl, output int extra, output logic [31:0] res_k1);
    lat    = 0;
    bc     = 0;
    ovl    = 0;
    extra  = 0;
    res_k1 = result;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (poke_at != 0 && k == poke_at) begin
        start = 1'b1;
        op_i  = OP_MUL;
        a_i   = 32'd5;
        b_i   = 32'd5;
      end
      if (poke_at != 0 && k == poke_at + 1) start = 1'b0;
      if (busy) bc++;
      if (busy && done) ovl++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      if (done) extra++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, bc, ovl, extra, exp_lat;
    logic [31:0] r1;
    exp_lat = is_div(v.op) ? LAT_DIV : LAT;
    issue(v.op, v.a, v.b, 1'b0);
    wait_done(0, 1, lat, bc, ovl, extra, r1);
    check({v.name, " latency"}, lat, exp_lat);
    check({v.name, " result"}, result, v.res);
    check({v.name, " busy_cycles"}, bc, exp_lat - 1);
    check({v.name, " busy_with_done"}, ovl, 0);
    check({v.name, " done_width"}, extra, 0);
  endtask

  initial begin
    int lat, bc, ovl, extra, nd;
    logic [31:0] r1;
    op_e  op_r;
    logic [31:0] res_r;

    rst   = 1'b1;
    start = 1'b0;
    op_i  = 3'b000;
    a_i   = '0;
    b_i   = '0;

    vecs.push_back('{OP_MUL,    32'd7,        32'd6,        32'd42,       "mul_7x6"});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1xm1"});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1xmax"});
    vecs.push_back('{OP_MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mul_min_m1"});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_minxmin"});
    vecs.push_back('{OP_MULH,   32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, "mulh_neg_2p32"});
    vecs.push_back('{OP_MULHU,  32'h80000000, 32'd2,        32'd1,        "mulhu_2p32"});
    vecs.push_back('{OP_MUL,    32'h12345678, 32'd0,        32'd0,        "mul_by_zero"});
`ifdef MULDIV_SEQ_DIV_EN
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"});
    vecs.push_back('{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2"});
    vecs.push_back('{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        "rem_7_m2"});
    vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0"});
    vecs.push_back('{OP_REM,    32'd5,        32'd0,        32'd5,        "rem_by0"});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFFF, "div_neg_by0"});
    vecs.push_back('{OP_REM,    32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, "rem_neg_by0"});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf"});
    vecs.push_back('{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        "divu_min_max"});
    vecs.push_back('{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, "remu_min_max"});
    vecs.push_back('{OP_REMU,   32'hFFFFFFFF, 32'h10,       32'hF,        "remu_max_16"});
    vecs.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, "divu_max_1"});
`else
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'd0,        "div_absent"});
    vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd0,        "remu_absent"});
    vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'd0,        "divu_absent"});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // A second start mid-operation must be ignored.
    issue(OP_MUL, 32'd3, 32'd4, 1'b0);
    wait_done(10, 5, lat, bc, ovl, extra, r1);
    check("ignore_start latency", lat, LAT);
    check("ignore_start result", result, 32'd12);
    check("ignore_start extra_done", extra, 0);

    // Back-to-back: accept in the IDLE cycle right after done; old result holds meanwhile.
    issue(OP_MUL, 32'd7, 32'd6, 1'b0);
    wait_done(0, 1, lat, bc, ovl, extra, r1);
    check("b2b first result", result, 32'd42);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done(0, 1, lat, bc, ovl, extra, r1);
    check("b2b result_hold", r1, 32'd42);
    check("b2b second latency", lat, LAT);
    check("b2b second result", result, 32'hFFFFFFFE);

    // Reset at cycle N+20 aborts the op; a start during reset is dropped.
`ifdef MULDIV_SEQ_DIV_EN
    op_r  = OP_DIVU;
    res_r = 32'd14;
`else
    op_r  = OP_MUL;
    res_r = 32'd700;
`endif
    issue(op_r, 32'd100, 32'd7, 1'b0);
    nd = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort busy_before_rst", 32'(busy), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    if (done) nd++;
    check("abort no_done", nd, 0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    issue(op_r, 32'd100, 32'd7, 1'b0);
    wait_done(0, 1, lat, bc, ovl, extra, r1);
    check("after_abort latency", lat, LAT);
    check("after_abort result", result, res_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
